// File: rtl/data_memory_ctrl.sv
// Data memory with byte-lane writes, pipelined read with valid strobe, range check and post-reset clear sweep.
// Reads return READ_LATENCY cycles after acceptance; all requests are dropped while busy is high.
module data_memory_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 256,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_valid,
  output logic                    addr_error,
  output logic                    busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      cnt_q;
  logic                  busy_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem_q    [DEPTH];
  logic                  rd_vld_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] rd_dat_q [READ_LATENCY];

  logic                  accept_d;
  logic                  in_range_d;
  logic                  rd_acc_d;
  logic                  wr_acc_d;
  logic [IDX_W-1:0]      idx_d;
  logic [DATA_WIDTH-1:0] rd_word_d;

  // Full-width compare so upper address bits can never alias onto a valid word.
  always_comb begin
    accept_d   = !busy_q && (MemRead || MemWrite);
    in_range_d = {1'b0, address} < DEPTH_L;
    idx_d      = address[IDX_W-1:0];
    rd_acc_d   = accept_d && MemRead;
    wr_acc_d   = accept_d && MemWrite && in_range_d;
    rd_word_d  = '0;
    if (rd_acc_d && in_range_d) rd_word_d = mem_q[idx_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      busy_q  <= (CLEAR_ON_RESET != 0);
      cnt_q   <= '0;
    end else if (state_q == CLEAR) begin
      cnt_q <= cnt_q + IDX_W'(1);
      if (cnt_q == LAST_IDX) begin
        state_q <= READY;
        busy_q  <= 1'b0;
      end
    end
  end

  // Invalid slots carry zero data, so the last stage drives read_data directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_vld_q[i] <= 1'b0;
        rd_dat_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      rd_vld_q[0] <= rd_acc_d;
      rd_dat_q[0] <= rd_word_d;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_dat_q[i] <= rd_dat_q[i-1];
      end
      err_q <= accept_d && !in_range_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc_d) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) mem_q[idx_d][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  assign read_data  = rd_dat_q[READ_LATENCY-1];
  assign read_valid = rd_vld_q[READ_LATENCY-1];
  assign addr_error = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomised scoreboard bench for data_memory_ctrl (DEPTH=256, READ_LATENCY=3, clear sweep on).
module tb_data_memory_ctrl;

  localparam int LAT   = 3;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [15:0] address = '0;
  logic [15:0] write_data = '0;
  logic [1:0]  byte_en = '0;
  logic [15:0] read_data;
  logic        read_valid;
  logic        addr_error;
  logic        busy;

  data_memory_ctrl #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(DEPTH),
    .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
  ) u_dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .write_data(write_data), .byte_en(byte_en),
    .read_data(read_data), .read_valid(read_valid),
    .addr_error(addr_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t     rq[$];
  bit          err_at[int];
  logic [15:0] ref_mem [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  bit          run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: outputs are registered, so sampling on the falling edge is race-free.
  always @(negedge clk) begin
    if (run && !reset) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        chk("read_valid", {31'd0, read_valid}, 32'd1);
        chk("read_data", {16'd0, read_data}, {16'd0, rq[0].data});
        void'(rq.pop_front());
      end else begin
        chk("read_valid_idle", {31'd0, read_valid}, 32'd0);
        chk("read_data_idle", {16'd0, read_data}, 32'd0);
      end
      chk("addr_error", {31'd0, addr_error}, {31'd0, err_at.exists(cyc)});
      if (err_at.exists(cyc)) err_at.delete(cyc);
    end
  end

  // Issue one request on the next rising edge and record what the memory should do.
  task automatic op(input bit rd, input bit wr, input logic [15:0] a,
                    input logic [15:0] d, input logic [1:0] be);
    int          k;
    bit          inr;
    logic [15:0] m;
    k          = cyc + 1;
    inr        = int'(a) < DEPTH;
    MemRead    = rd;
    MemWrite   = wr;
    address    = a;
    write_data = d;
    byte_en    = be;
    if (rd) rq.push_back('{inr ? ref_mem[int'(a)] : 16'h0000, k + LAT - 1});
    if ((rd || wr) && !inr) err_at[k] = 1'b1;
    if (wr && inr) begin
      m = {{8{be[1]}}, {8{be[0]}}};
      ref_mem[int'(a)] = (ref_mem[int'(a)] & ~m) | (d & m);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Requests held high through the sweep must be dropped entirely.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_read_valid", {31'd0, read_valid}, 32'd0);
    chk("rst_addr_error", {31'd0, addr_error}, 32'd0);
    chk("rst_read_data", {16'd0, read_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    rq.delete();
    err_at.delete();
    MemRead    = 1'b1;
    MemWrite   = 1'b1;
    address    = 16'd5;
    write_data = 16'hFFFF;
    byte_en    = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;
  endtask

  task automatic sweep_wait();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (busy && n < 2000);
    chk("busy_cycles", n, 32'd256);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    @(negedge clk);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 16'(i), 16'h0, 2'b00);
  endtask

  initial begin
    int r;
    logic [15:0] a;
    #1;
    @(negedge clk);
    do_reset();
    sweep_wait();
    read_all();

    op(1'b0, 1'b1, 16'd5, 16'hBEEF, 2'b11);
    op(1'b0, 1'b1, 16'd5, 16'h1234, 2'b01);
    op(1'b1, 1'b0, 16'd5, 16'h0000, 2'b00);
    op(1'b0, 1'b1, 16'd1, 16'h0011, 2'b11);
    op(1'b0, 1'b1, 16'd2, 16'h0022, 2'b11);
    op(1'b0, 1'b1, 16'd3, 16'h0033, 2'b11);
    op(1'b1, 1'b0, 16'd1, 16'h0000, 2'b00);
    op(1'b1, 1'b0, 16'd2, 16'h0000, 2'b00);
    op(1'b1, 1'b0, 16'd3, 16'h0000, 2'b00);
    op(1'b0, 1'b1, 16'd7, 16'hAAAA, 2'b11);
    op(1'b1, 1'b1, 16'd7, 16'h5555, 2'b11);
    op(1'b1, 1'b0, 16'd7, 16'h0000, 2'b00);
    op(1'b0, 1'b1, 16'd256, 16'hFFFF, 2'b11);
    op(1'b1, 1'b0, 16'd0, 16'h0000, 2'b00);
    op(1'b1, 1'b0, 16'd300, 16'h0000, 2'b00);
    op(1'b0, 1'b1, 16'h0105, 16'hCAFE, 2'b11);
    op(1'b1, 1'b0, 16'd5, 16'h0000, 2'b00);
    op(1'b0, 1'b1, 16'd9, 16'h9999, 2'b00);
    op(1'b1, 1'b0, 16'd9, 16'h0000, 2'b00);
    idle(LAT + 2);

    repeat (2000) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 15) == 0) a = 16'($urandom);
      else if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 15));
      else a = 16'($urandom_range(0, 299));
      op(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, a,
         16'($urandom), 2'($urandom));
    end
    read_all();
    idle(LAT + 2);

    // Reset with two reads in flight: their results must never appear.
    op(1'b1, 1'b0, 16'd5, 16'h0000, 2'b00);
    op(1'b1, 1'b0, 16'd6, 16'h0000, 2'b00);
    do_reset();
    sweep_wait();
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 16'(i), 16'h0000, 2'b00);
    idle(LAT + 2);

    // Reset partway through the sweep restarts it from word 0.
    do_reset();
    repeat (100) @(posedge clk);
    @(negedge clk);
    do_reset();
    sweep_wait();
    read_all();
    idle(LAT + 2);

    chk("queue_drained", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
